// File: rtl/secmem_dumper.sv
// Initiator for the secure-memory link: walks all 32 remote addresses, double-samples
// each returned byte for stability (with bounded retries) and keeps the results in a readable buffer.
module secmem_dumper #(
  parameter int unsigned CLK_FREQ      = 103_340_000,
  parameter int unsigned SETTLE_CYCLES = CLK_FREQ / 5,
  parameter int unsigned SAMPLE_GAP    = CLK_FREQ / 20,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [2:0]  MODE_SECMEM   = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [2:0]  mode_out,
  output logic [4:0]  addr_out,
  output logic        bus_oe,
  input  logic [7:0]  value_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] err_mask,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE_A, S_GAP, S_SAMPLE_B, S_CHECK, S_NEXT
  } state_t;

  // Values of 0 or 1 both collapse to a single-cycle wait state.
  localparam logic [31:0] SETTLE_LOAD = (SETTLE_CYCLES <= 1) ? 32'd0 : 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD    = (SAMPLE_GAP <= 1)    ? 32'd0 : 32'(SAMPLE_GAP - 1);
  localparam logic [31:0] RETRY_MAX   = 32'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] retry_q, retry_d;
  logic [4:0]  addr_q, addr_d;
  logic [2:0]  mode_q, mode_d;
  logic        bus_oe_q, bus_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] err_mask_q, err_mask_d;
  logic [7:0]  s_a_q, s_a_d;
  logic [7:0]  s_b_q, s_b_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [7:0]  rd_data_q;
  logic        wr_en_s;
  logic [7:0]  wr_data_s;
  logic [7:0]  mem_q [32];

  // Two-flop synchronizer for the asynchronous remote value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= value_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and registered-output logic of the dump sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    bus_oe_d   = bus_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_mask_d = err_mask_q;
    s_a_d      = s_a_q;
    s_b_d      = s_b_q;
    wr_en_s    = 1'b0;
    wr_data_s  = s_a_q;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          addr_d     = 5'd0;
          retry_d    = 32'd0;
          err_mask_d = 32'd0;
          busy_d     = 1'b1;
          bus_oe_d   = 1'b1;
          mode_d     = MODE_SECMEM;
          cnt_d      = SETTLE_LOAD;
          state_d    = S_SETTLE;
        end else begin
          bus_oe_d = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 32'd0) begin
          state_d = S_SAMPLE_A;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_SAMPLE_A: begin
        s_a_d   = sync2_q;
        cnt_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == 32'd0) begin
          state_d = S_SAMPLE_B;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_SAMPLE_B: begin
        s_b_d   = sync2_q;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (s_a_q == s_b_q) begin
          wr_en_s   = 1'b1;
          wr_data_s = s_a_q;
          state_d   = S_NEXT;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 32'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end else begin
          wr_en_s            = 1'b1;
          wr_data_s          = s_b_q;
          err_mask_d[addr_q] = 1'b1;
          state_d            = S_NEXT;
        end
      end
      S_NEXT: begin
        retry_d = 32'd0;
        if (addr_q == 5'd31) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          bus_oe_d = 1'b0;
          mode_d   = 3'b000;
          addr_d   = 5'd0;
          state_d  = S_IDLE;
        end else begin
          addr_d  = addr_q + 5'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      retry_q    <= 32'd0;
      addr_q     <= 5'd0;
      mode_q     <= 3'b000;
      bus_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_mask_q <= 32'd0;
      s_a_q      <= 8'h00;
      s_b_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      bus_oe_q   <= bus_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_mask_q <= err_mask_d;
      s_a_q      <= s_a_d;
      s_b_q      <= s_b_d;
    end
  end

  // Result buffer survives reset so a partial dump can still be read out.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[addr_q] <= wr_data_s;
    end
  end

  // Registered read port; a same-cycle write returns the previous contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign mode_out = mode_q;
  assign addr_out = addr_q;
  assign bus_oe   = bus_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_mask = err_mask_q;
  assign rd_data  = rd_data_q;

endmodule
